// File: rtl/video_timing_gen_pkg.sv
// Shared types, default widths and reset-edge macros for the video timing generator.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
`ifndef VIDEO_TIMING_GEN_MACROS
`define VIDEO_TIMING_GEN_MACROS
`define CLK_RST_EDGE posedge clk or posedge rst
`define RST rst
`endif

package video_timing_gen_pkg;

    localparam int W_PW_DEF = 11;
    localparam int W_PH_DEF = 11;

    typedef enum logic [1:0] {
        PH_ACT  = 2'd0,
        PH_FP   = 2'd1,
        PH_SYNC = 2'd2,
        PH_BP   = 2'd3
    } phase_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

endpackage

// File: rtl/video_timing_gen_phase_cnt.sv
// Four-phase sequencer (ACT, FP, SYNC, BP) with a per-phase length counter.
// Latency: phase/count update on the clock after step; last/wrap are combinational.
// Backpressure: none; the counter only advances when step is high.
// Ports: clk/rst, step, len_act/len_fp/len_sync/len_bp -> phase, count, last, wrap.
module vtg_phase_cnt
    import video_timing_gen_pkg::*;
#(
    parameter int W = 11
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         step,
    input  logic [W:0]   len_act,
    input  logic [W:0]   len_fp,
    input  logic [W:0]   len_sync,
    input  logic [W:0]   len_bp,
    output phase_e       phase,
    output logic [W:0]   count,
    output logic         last,
    output logic         wrap
);

    localparam logic [W:0] ONE = {{W{1'b0}}, 1'b1};

    logic [W:0] cur_len;
    phase_e     phase_nxt;

    always_comb begin
        cur_len   = len_act;
        phase_nxt = PH_ACT;
        case (phase)
            PH_ACT:  begin
                cur_len   = len_act;
                // ACT and SYNC are never empty, so only the porches need skipping.
                phase_nxt = (len_fp != '0) ? PH_FP : PH_SYNC;
            end
            PH_FP:   begin
                cur_len   = len_fp;
                phase_nxt = PH_SYNC;
            end
            PH_SYNC: begin
                cur_len   = len_sync;
                phase_nxt = (len_bp != '0) ? PH_BP : PH_ACT;
            end
            PH_BP:   begin
                cur_len   = len_bp;
                phase_nxt = PH_ACT;
            end
            default: begin
                cur_len   = len_act;
                phase_nxt = PH_ACT;
            end
        endcase
    end

    assign last = (count == (cur_len - ONE));
    // Final cycle of the whole period: last cycle of BP, or of SYNC when BP is empty.
    assign wrap = last && ((phase == PH_BP) || ((phase == PH_SYNC) && (len_bp == '0)));

    always_ff @(`CLK_RST_EDGE) begin
        if (`RST) begin
            phase <= PH_ACT;
            count <= '0;
        end else if (step) begin
            if (last) begin
                phase <= phase_nxt;
                count <= '0;
            end else begin
                count <= count + ONE;
            end
        end
    end

endmodule

// File: rtl/video_timing_gen.sv
// Raster timing source: vsync/hsync/de plus active coordinates and frame/line strobes.
// Latency: de rises 1 cycle after en is sampled high in idle; all outputs registered.
// Backpressure: none; en is sampled only when idle or at a frame boundary, frames never truncate.
// Ports: clk, rst, en, pic_width/height, h_fp/h_sync/h_bp, v_fp/v_sync/v_bp ->
//        vsync, hsync, de, cnt_h, cnt_v, frame_start, line_start, busy.
module video_timing_gen
    import video_timing_gen_pkg::*;
#(
    parameter int W_PW = W_PW_DEF,
    parameter int W_PH = W_PH_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic [W_PW:0]   pic_width,
    input  logic [W_PH:0]   pic_height,
    input  logic [W_PW:0]   h_fp,
    input  logic [W_PW:0]   h_sync,
    input  logic [W_PW:0]   h_bp,
    input  logic [W_PH:0]   v_fp,
    input  logic [W_PH:0]   v_sync,
    input  logic [W_PH:0]   v_bp,
    output logic            vsync,
    output logic            hsync,
    output logic            de,
    output logic [W_PW:0]   cnt_h,
    output logic [W_PH:0]   cnt_v,
    output logic            frame_start,
    output logic            line_start,
    output logic            busy
);

    // The phase counters hold the raster position of the pixel about to be
    // emitted; outputs register the decode of that position. After the last
    // pixel of a frame is emitted the counters sit at the origin again, and the
    // FSM returns to IDLE so the next edge decides between restart and stop.
    state_e state, state_nxt;

    logic [W_PW:0] sh_width, sh_hfp, sh_hsync, sh_hbp;
    logic [W_PH:0] sh_height, sh_vfp, sh_vsync, sh_vbp;
    logic [W_PW:0] e_width, e_hfp, e_hsync, e_hbp;
    logic [W_PH:0] e_height, e_vfp, e_vsync, e_vbp;

    logic          go, running, frame_end;
    phase_e        h_phase, v_phase;
    logic [W_PW:0] h_count;
    logic [W_PH:0] v_count;
    logic          h_wrap, v_wrap, h_last_unused, v_last_unused;

    logic          de_nxt, hsync_nxt, vsync_nxt, fs_nxt, ls_nxt;
    logic [W_PW:0] cnt_h_nxt;
    logic [W_PH:0] cnt_v_nxt;

    assign go      = (state == ST_IDLE) && en;
    assign running = (state == ST_RUN) || go;

    // On the latch cycle the counters must already step with the new config.
    assign e_width  = go ? pic_width  : sh_width;
    assign e_hfp    = go ? h_fp       : sh_hfp;
    assign e_hsync  = go ? h_sync     : sh_hsync;
    assign e_hbp    = go ? h_bp       : sh_hbp;
    assign e_height = go ? pic_height : sh_height;
    assign e_vfp    = go ? v_fp       : sh_vfp;
    assign e_vsync  = go ? v_sync     : sh_vsync;
    assign e_vbp    = go ? v_bp       : sh_vbp;

    vtg_phase_cnt #(.W(W_PW)) u_h_cnt (
        .clk      (clk),
        .rst      (rst),
        .step     (running),
        .len_act  (e_width),
        .len_fp   (e_hfp),
        .len_sync (e_hsync),
        .len_bp   (e_hbp),
        .phase    (h_phase),
        .count    (h_count),
        .last     (h_last_unused),
        .wrap     (h_wrap)
    );

    vtg_phase_cnt #(.W(W_PH)) u_v_cnt (
        .clk      (clk),
        .rst      (rst),
        .step     (running && h_wrap),
        .len_act  (e_height),
        .len_fp   (e_vfp),
        .len_sync (e_vsync),
        .len_bp   (e_vbp),
        .phase    (v_phase),
        .count    (v_count),
        .last     (v_last_unused),
        .wrap     (v_wrap)
    );

    assign frame_end = running && h_wrap && v_wrap;

    always_ff @(`CLK_RST_EDGE) begin
        if (`RST) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        de_nxt    = 1'b0;
        hsync_nxt = 1'b0;
        vsync_nxt = 1'b0;
        fs_nxt    = 1'b0;
        ls_nxt    = 1'b0;
        cnt_h_nxt = '0;
        cnt_v_nxt = '0;
        case (state)
            ST_IDLE: if (en)        state_nxt = ST_RUN;
            ST_RUN:  if (frame_end) state_nxt = ST_IDLE;
            default:                state_nxt = ST_IDLE;
        endcase
        if (running) begin
            de_nxt    = (h_phase == PH_ACT) && (v_phase == PH_ACT);
            hsync_nxt = (h_phase == PH_SYNC);
            vsync_nxt = (v_phase == PH_SYNC);
            cnt_h_nxt = de_nxt ? h_count : '0;
            // Past the active lines the line count has advanced to pic_height.
            cnt_v_nxt = (v_phase == PH_ACT) ? v_count : sh_height;
            ls_nxt    = de_nxt && (h_count == '0);
            fs_nxt    = ls_nxt && (v_count == '0);
        end
    end

    always_ff @(`CLK_RST_EDGE) begin
        if (`RST) begin
            sh_width  <= '0;
            sh_hfp    <= '0;
            sh_hsync  <= '0;
            sh_hbp    <= '0;
            sh_height <= '0;
            sh_vfp    <= '0;
            sh_vsync  <= '0;
            sh_vbp    <= '0;
        end else if (go) begin
            sh_width  <= pic_width;
            sh_hfp    <= h_fp;
            sh_hsync  <= h_sync;
            sh_hbp    <= h_bp;
            sh_height <= pic_height;
            sh_vfp    <= v_fp;
            sh_vsync  <= v_sync;
            sh_vbp    <= v_bp;
        end
    end

    always_ff @(`CLK_RST_EDGE) begin
        if (`RST) begin
            de          <= 1'b0;
            hsync       <= 1'b0;
            vsync       <= 1'b0;
            cnt_h       <= '0;
            cnt_v       <= '0;
            frame_start <= 1'b0;
            line_start  <= 1'b0;
            busy        <= 1'b0;
        end else begin
            de          <= de_nxt;
            hsync       <= hsync_nxt;
            vsync       <= vsync_nxt;
            cnt_h       <= cnt_h_nxt;
            cnt_v       <= cnt_v_nxt;
            frame_start <= fs_nxt;
            line_start  <= ls_nxt;
            busy        <= running;
        end
    end

endmodule

// File: tb/tb_video_timing_gen.sv
// Self-checking bench for video_timing_gen against a frame-position reference model.
// Latency: n/a.
// Backpressure: n/a.
module tb_video_timing_gen;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        en  = 1'b0;
    logic [11:0] pic_width = 12'd8, pic_height = 12'd4;
    logic [11:0] h_fp = 12'd2, h_sync = 12'd3, h_bp = 12'd1;
    logic [11:0] v_fp = 12'd1, v_sync = 12'd2, v_bp = 12'd1;
    logic        vsync, hsync, de, frame_start, line_start, busy;
    logic [11:0] cnt_h, cnt_v;

    video_timing_gen #(.W_PW(11), .W_PH(11)) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .pic_width   (pic_width),
        .pic_height  (pic_height),
        .h_fp        (h_fp),
        .h_sync      (h_sync),
        .h_bp        (h_bp),
        .v_fp        (v_fp),
        .v_sync      (v_sync),
        .v_bp        (v_bp),
        .vsync       (vsync),
        .hsync       (hsync),
        .de          (de),
        .cnt_h       (cnt_h),
        .cnt_v       (cnt_v),
        .frame_start (frame_start),
        .line_start  (line_start),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int w, h, hfp, hs, hbp, vfp, vs, vbp;
    } cfg_t;

    // Reference model: a running flag, the frame config and the cycle index
    // within the current frame. Everything else is derived arithmetically.
    cfg_t m_cfg;
    bit   m_run = 1'b0;
    int   m_k   = 0;

    function automatic cfg_t cur_inputs();
        cfg_t c;
        c.w = int'(pic_width);  c.h  = int'(pic_height);
        c.hfp = int'(h_fp);     c.hs = int'(h_sync);  c.hbp = int'(h_bp);
        c.vfp = int'(v_fp);     c.vs = int'(v_sync);  c.vbp = int'(v_bp);
        return c;
    endfunction

    function automatic int line_len(cfg_t c);
        return c.w + c.hfp + c.hs + c.hbp;
    endfunction

    function automatic int frame_len(cfg_t c);
        return line_len(c) * (c.h + c.vfp + c.vs + c.vbp);
    endfunction

    function automatic logic [29:0] exp_vec();
        int          L, line, x;
        logic        e_de, e_hs, e_vs;
        logic [11:0] ch, cv;
        if (!m_run) return '0;
        L    = line_len(m_cfg);
        line = m_k / L;
        x    = m_k % L;
        e_de = (x < m_cfg.w) && (line < m_cfg.h);
        e_hs = (x >= m_cfg.w + m_cfg.hfp) && (x < m_cfg.w + m_cfg.hfp + m_cfg.hs);
        e_vs = (line >= m_cfg.h + m_cfg.vfp) && (line < m_cfg.h + m_cfg.vfp + m_cfg.vs);
        ch   = e_de ? 12'(x) : 12'd0;
        cv   = e_de ? 12'(line) : 12'd0;
        return {e_vs, e_hs, e_de, ch, cv, (m_k == 0), (e_de && x == 0), 1'b1};
    endfunction

    // cnt_v is only defined during de, so it is masked elsewhere.
    function automatic logic [29:0] obs();
        return {vsync, hsync, de, cnt_h, (de ? cnt_v : 12'd0), frame_start, line_start, busy};
    endfunction

    // Advance one clock: update the model with the inputs the DUT samples,
    // then return at the falling edge where outputs are compared.
    task automatic tick();
        @(posedge clk);
        if (rst) begin
            m_run = 1'b0;
        end else if (m_run) begin
            m_k++;
            if (m_k == frame_len(m_cfg)) begin
                if (en) begin
                    m_cfg = cur_inputs();
                    m_k   = 0;
                end else begin
                    m_run = 1'b0;
                end
            end
        end else if (en) begin
            m_run = 1'b1;
            m_cfg = cur_inputs();
            m_k   = 0;
        end
        @(negedge clk);
    endtask

    task automatic set_cfg(int w, int h, int hfp, int hs, int hbp, int vfp, int vs, int vbp);
        pic_width = 12'(w);  pic_height = 12'(h);
        h_fp = 12'(hfp);     h_sync = 12'(hs);   h_bp = 12'(hbp);
        v_fp = 12'(vfp);     v_sync = 12'(vs);   v_bp = 12'(vbp);
    endtask

    task automatic do_reset();
        en    = 1'b0;
        rst   = 1'b1;
        m_run = 1'b0;
        repeat (2) @(negedge clk);
        rst   = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        #1 rst = 1'b1;
        #1;
        checks++;
        if (obs() !== 30'd0) begin
            errors++;
            $display("FAIL reset_outputs got %h want 0", obs());
        end
        do_reset();
    endtask

    task automatic test_small_frame();
        int de_n = 0, hs_n = 0, vs_n = 0, vs_first = -1, vs_last = -1;
        int fs_idx[$];
        int max_h = 0, max_v = 0;
        do_reset();
        set_cfg(8, 4, 2, 3, 1, 1, 2, 1);
        en = 1'b1;
        for (int i = 0; i < 240; i++) begin
            tick();
            checks++;
            if (obs() !== exp_vec()) begin
                errors++;
                $display("FAIL small_frame cyc=%0d got %h want %h", i, obs(), exp_vec());
            end
            if (frame_start) fs_idx.push_back(i);
            if (i < 112 && de) de_n++;
            if (i < 14 && hsync) hs_n++;
            if (i < 112 && vsync) begin
                vs_n++;
                if (vs_first < 0) vs_first = i;
                vs_last = i;
            end
            if (de && int'(cnt_h) > max_h) max_h = int'(cnt_h);
            if (de && int'(cnt_v) > max_v) max_v = int'(cnt_v);
            if (line_start) begin
                checks++;
                if (!(de && cnt_h == 12'd0)) begin
                    errors++;
                    $display("FAIL line_start_align cyc=%0d de=%0b cnt_h=%0d want de=1 cnt_h=0", i, de, cnt_h);
                end
            end
        end
        checks++;
        if (de_n != 32) begin errors++; $display("FAIL de_per_frame got %0d want 32", de_n); end
        checks++;
        if (hs_n != 3) begin errors++; $display("FAIL hsync_per_line got %0d want 3", hs_n); end
        checks++;
        if (vs_n != 28 || vs_last - vs_first + 1 != 28) begin
            errors++;
            $display("FAIL vsync_run got n=%0d span=%0d want 28", vs_n, vs_last - vs_first + 1);
        end
        checks++;
        if (fs_idx.size() < 3 || fs_idx[1] - fs_idx[0] != 112 || fs_idx[2] - fs_idx[1] != 112) begin
            errors++;
            $display("FAIL frame_period got %0d starts want 112 spacing", fs_idx.size());
        end
        checks++;
        if (max_h != 7 || max_v != 3) begin
            errors++;
            $display("FAIL coord_range got h=%0d v=%0d want h=7 v=3", max_h, max_v);
        end
    endtask

    task automatic test_zero_porch();
        int fs_idx[$];
        do_reset();
        set_cfg(4, 2, 0, 1, 0, 0, 1, 0);
        en = 1'b1;
        for (int i = 0; i < 50; i++) begin
            tick();
            checks++;
            if (obs() !== exp_vec()) begin
                errors++;
                $display("FAIL zero_porch cyc=%0d got %h want %h", i, obs(), exp_vec());
            end
            if (frame_start) fs_idx.push_back(i);
        end
        checks++;
        if (fs_idx.size() < 4 || fs_idx[0] != 0 || fs_idx[1] != 15 || fs_idx[2] != 30 || fs_idx[3] != 45) begin
            errors++;
            $display("FAIL zero_porch_period got %0d starts want 0,15,30,45", fs_idx.size());
        end
    endtask

    task automatic test_midframe_cfg();
        int fs_idx[$];
        do_reset();
        set_cfg(8, 4, 2, 3, 1, 1, 2, 1);
        en = 1'b1;
        for (int i = 0; i < 260; i++) begin
            tick();
            checks++;
            if (obs() !== exp_vec()) begin
                errors++;
                $display("FAIL midframe_cfg cyc=%0d got %h want %h", i, obs(), exp_vec());
            end
            if (frame_start) fs_idx.push_back(i);
            if (i == 50) pic_width = 12'd6;
        end
        checks++;
        if (fs_idx.size() < 3 || fs_idx[1] != 112 || fs_idx[2] != 208) begin
            errors++;
            $display("FAIL midframe_period got %0d starts want 112,208", fs_idx.size());
        end
    endtask

    task automatic test_en_drop();
        int last_busy = -1;
        do_reset();
        set_cfg(8, 4, 2, 3, 1, 1, 2, 1);
        en = 1'b1;
        for (int i = 0; i < 150; i++) begin
            tick();
            checks++;
            if (obs() !== exp_vec()) begin
                errors++;
                $display("FAIL en_drop cyc=%0d got %h want %h", i, obs(), exp_vec());
            end
            if (busy) last_busy = i;
            if (i == 30) en = 1'b0;
        end
        checks++;
        if (last_busy != 111) begin
            errors++;
            $display("FAIL busy_fall got last=%0d want 111", last_busy);
        end
        en = 1'b1;
        tick();
        checks++;
        if (!(de && frame_start && busy) || obs() !== exp_vec()) begin
            errors++;
            $display("FAIL restart got %h want %h", obs(), exp_vec());
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        set_cfg(8, 4, 2, 3, 1, 1, 2, 1);
        en = 1'b1;
        for (int i = 0; i <= 40; i++) begin
            tick();
            checks++;
            if (obs() !== exp_vec()) begin
                errors++;
                $display("FAIL pre_reset cyc=%0d got %h want %h", i, obs(), exp_vec());
            end
        end
        #2 rst = 1'b1;
        m_run = 1'b0;
        #1;
        checks++;
        if (obs() !== 30'd0) begin
            errors++;
            $display("FAIL async_reset got %h want 0", obs());
        end
        @(negedge clk);
        rst = 1'b0;
        tick();
        checks++;
        if (!(frame_start && de && cnt_h == 12'd0 && cnt_v == 12'd0) || obs() !== exp_vec()) begin
            errors++;
            $display("FAIL post_reset got %h want %h", obs(), exp_vec());
        end
    endtask

    task automatic test_random();
        for (int r = 0; r < 3; r++) begin
            do_reset();
            set_cfg($urandom_range(12, 1), $urandom_range(5, 1), $urandom_range(3, 0),
                    $urandom_range(3, 1), $urandom_range(3, 0), $urandom_range(2, 0),
                    $urandom_range(2, 1), $urandom_range(2, 0));
            en = 1'b1;
            for (int i = 0; i < 500; i++) begin
                tick();
                checks++;
                if (obs() !== exp_vec()) begin
                    errors++;
                    $display("FAIL random r=%0d cyc=%0d got %h want %h", r, i, obs(), exp_vec());
                end
                if ($urandom_range(49, 0) == 0)
                    set_cfg($urandom_range(12, 1), $urandom_range(5, 1), $urandom_range(3, 0),
                            $urandom_range(3, 1), $urandom_range(3, 0), $urandom_range(2, 0),
                            $urandom_range(2, 1), $urandom_range(2, 0));
                if ($urandom_range(59, 0) == 0) en = ~en;
            end
        end
    endtask

    initial begin
        test_reset();
        test_small_frame();
        test_zero_porch();
        test_midframe_cfg();
        test_en_drop();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/video_timing_gen.md
Name: video_timing_gen

Overview:
- Generates the raster video timing stream (vsync, hsync, de) that pixel-domain overlay and CNN-front-end blocks consume.
- Emits per-pixel active coordinates and frame/line strobes alongside the timing.
- Resolution and blanking are runtime-programmable and take effect only on frame boundaries.
- Sits at the head of the display/test pipeline as the timing source for the rectangle overlay and frame-buffer readers.

Parameters:
- W_PW, 11: horizontal field MSB index; horizontal fields are W_PW+1 bits.
- W_PH, 11: vertical field MSB index; vertical fields are W_PH+1 bits.

Ports:
- clk  in  1  pixel clock.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  run request, level-sensitive.
- pic_width  in  W_PW+1  active pixels per line, >=1.
- pic_height  in  W_PH+1  active lines per frame, >=1.
- h_fp, h_sync, h_bp  in  W_PW+1 each  horizontal front porch, sync and back porch in cycles; h_sync >=1, porches may be 0.
- v_fp, v_sync, v_bp  in  W_PH+1 each  vertical front porch, sync and back porch in lines; v_sync >=1, porches may be 0.
- vsync  out  1  active-high vertical sync.
- hsync  out  1  active-high horizontal sync.
- de  out  1  active-video enable.
- cnt_h  out  W_PW+1  active pixel x; 0 when de=0.
- cnt_v  out  W_PH+1  active line y; holds during horizontal blanking.
- frame_start  out  1  one-cycle pulse coincident with pixel (0,0).
- line_start  out  1  one-cycle pulse on the first de cycle of each line.
- busy  out  1  high while a frame is in progress.

Behaviour:
- Reset and idle:
  - All outputs are 0 while reset is asserted.
  - The FSM resets to IDLE.
- Top FSM states: IDLE, RUN.
- IDLE to RUN:
  - Transition occurs on the first cycle with en=1.
  - On that cycle all config inputs are latched into shadow registers.
  - The first active pixel appears on the next cycle. Latency from en sampled high to de=1 is 1 cycle.
- Horizontal phase sequence per line: H_ACT (pic_width cycles), H_FP, H_SYNC, H_BP.
  - Line length = pic_width + h_fp + h_sync + h_bp cycles.
- Vertical phase sequence per frame: V_ACT (pic_height lines), V_FP, V_SYNC, V_BP.
  - Vertical phase changes only at a line boundary, i.e. on the cycle after the last H_BP cycle.
- Zero-length phases:
  - Any porch programmed to 0 is skipped with no idle cycle.
  - A phase counter reaching length-1 advances to the next phase on the following cycle.
- Output decoding (all outputs registered):
  - de = H_ACT and V_ACT.
  - hsync = H_SYNC in every vertical phase.
  - vsync = V_SYNC for whole lines, from the first cycle of the line to the last cycle of the line.
- Counters:
  - cnt_h increments 0..pic_width-1 during de.
  - cnt_v increments after the last H_BP cycle of each active line, and is cleared at the frame boundary.
- Frame boundary (end of V_BP, last H_BP cycle):
  - If en=1: re-latch the config and start H_ACT/V_ACT of the next frame on the next cycle, with no gap.
  - If en=0: go to IDLE and drop busy.
  - Deasserting en mid-frame never truncates the frame. The frame always completes.
- Config changes mid-frame are ignored until the next frame boundary.
- Asserting reset mid-frame aborts immediately: all outputs go to 0 asynchronously.
- Counter widths:
  - Phase counters are W_PW+1 / W_PH+1 bits with no wrap inside a phase.
  - Values above field range are illegal and are not checked.
- busy is 1 from the first RUN cycle through the last H_BP cycle of the final frame.

Decomposition:
- Global package:
  - W_PW/W_PH defaults.
  - phase enum: PH_ACT, PH_FP, PH_SYNC, PH_BP.
  - The CLK_RST_EDGE/RST macro pair for async active-high reset.
- One sub-module, vtg_phase_cnt, instantiated twice:
  - Contents: a 4-phase sequencer with a length-per-phase counter.
  - Interface: step input, four lengths, phase, count, last-of-phase flag and wrap flag.
  - Horizontal instance steps every cycle.
  - Vertical instance steps on the horizontal wrap.

Test Plan:
- Small frame, en=1:
  - Config: 8x4, h_fp=2, h_sync=3, h_bp=1, v_fp=1, v_sync=2, v_bp=1.
  - Required: line = 14 cycles; frame = 8 lines = 112 cycles; 32 de cycles per frame; hsync 3 cycles per line; vsync high for 28 consecutive cycles; frame_start every 112 cycles.
- Zero porches:
  - Config: h_fp=h_bp=v_fp=v_bp=0, h_sync=v_sync=1, 4x2.
  - Required: line = 5 cycles; frame = 15 cycles; no dead cycles between phases.
- Coordinates:
  - Required: cnt_h runs 0..7 and cnt_v runs 0..3 during de; cnt_h=0 outside de; line_start coincides with cnt_h=0 and de=1.
- Mid-frame config change:
  - Stimulus: set pic_width=6 at cycle 50 of the small frame.
  - Required: current frame keeps 8-pixel lines; the next frame uses 6 (line = 12 cycles).
- en drop mid-frame:
  - Stimulus: en low at cycle 30.
  - Required: the frame completes all 112 cycles, busy falls after cycle 111, outputs stay 0 afterwards; re-assertion restarts with de 1 cycle after en.
- Async reset at cycle 40 of a frame:
  - Required: all outputs go to 0 immediately; after release with en=1, frame_start occurs 1 cycle later at (0,0).
